// File: rtl/sha256_core.sv
// Single-block SHA-256 engine: byte-per-beat AXI-Stream in, eight digest words out.
// Messages longer than 55 bytes are truncated so padding always fits one block.
module sha256_core (
  input  logic        m_axis_aclk,
  input  logic        m_axis_aresetn,
  input  logic        s_axis_tvalid,
  input  logic [3:0]  s_axis_tkeep,
  output logic        s_axis_tready,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tlast,
  output logic        m_axis_tvalid,
  output logic [3:0]  m_axis_tkeep,
  input  logic        m_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tlast
);

  typedef enum logic [2:0] {
    IDLE, PAD, SCHED, ROUND, FINAL, OUT
  } state_e;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] H0 [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction

  state_e      state_q, state_d;
  logic [31:0] w_array [0:63];
  logic [31:0] w_d     [0:63];
  logic [31:0] v_q     [0:7];
  logic [31:0] v_d     [0:7];
  logic [31:0] dig_q   [0:7];
  logic [31:0] dig_d   [0:7];
  logic [5:0]  len_q, len_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] t1, t2;
  logic        unused_in;

  assign unused_in = ^{s_axis_tkeep, s_axis_tdata[31:8]};

  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_aresetn) state_q <= IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (s_axis_tvalid && s_axis_tlast) state_d = PAD;
      PAD:     state_d = SCHED;
      SCHED:   if (cnt_q == 6'd63) state_d = ROUND;
      ROUND:   if (cnt_q == 6'd63) state_d = FINAL;
      FINAL:   state_d = OUT;
      OUT:     if (m_axis_tready && idx_q == 3'd7) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready = (state_q == IDLE) && !m_axis_aresetn;
    m_axis_tvalid = (state_q == OUT);
    m_axis_tdata  = (state_q == OUT) ? dig_q[idx_q] : '0;
    m_axis_tlast  = (state_q == OUT) && (idx_q == 3'd7);
    m_axis_tkeep  = 4'hF;
  end

  always_comb begin
    w_d   = w_array;
    v_d   = v_q;
    dig_d = dig_q;
    len_d = len_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    t1    = '0;
    t2    = '0;
    unique case (state_q)
      IDLE: begin
        // Bytes past the 55th are dropped so padding fits one block
        if (s_axis_tvalid && len_q < 6'd55) begin
          w_d[{2'b00, len_q[5:2]}][{~len_q[1:0], 3'b000} +: 8] =
            s_axis_tdata[7:0];
          len_d = len_q + 6'd1;
        end
      end
      PAD: begin
        for (int p = 0; p < 60; p++) begin
          if (6'(p) == len_q)
            w_d[p / 4][8 * (3 - p % 4) +: 8] = 8'h80;
          else if (6'(p) > len_q)
            w_d[p / 4][8 * (3 - p % 4) +: 8] = 8'h00;
        end
        w_d[14] = '0;
        w_d[15] = {23'd0, len_q, 3'd0};
        v_d     = H0;
        cnt_d   = 6'd16;
      end
      SCHED: begin
        w_d[cnt_q] = ssig1(w_array[cnt_q - 6'd2])
                   + w_array[cnt_q - 6'd7]
                   + ssig0(w_array[cnt_q - 6'd15])
                   + w_array[cnt_q - 6'd16];
        cnt_d = cnt_q + 6'd1;
      end
      ROUND: begin
        t1 = v_q[7] + bsig1(v_q[4])
           + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6]))
           + K[cnt_q] + w_array[cnt_q];
        t2 = bsig0(v_q[0])
           + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
        v_d[0] = t1 + t2;
        v_d[1] = v_q[0];
        v_d[2] = v_q[1];
        v_d[3] = v_q[2];
        v_d[4] = v_q[3] + t1;
        v_d[5] = v_q[4];
        v_d[6] = v_q[5];
        v_d[7] = v_q[6];
        cnt_d  = cnt_q + 6'd1;
      end
      FINAL: begin
        for (int i = 0; i < 8; i++) dig_d[i] = H0[i] + v_q[i];
        idx_d = '0;
      end
      OUT: begin
        if (m_axis_tready) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            len_d = '0;
            w_d   = '{default: '0};
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_aresetn) begin
      w_array <= '{default: '0};
      v_q     <= '{default: '0};
      dig_q   <= '{default: '0};
      len_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      w_array <= w_d;
      v_q     <= v_d;
      dig_q   <= dig_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_sha256_core.sv
// Randomised bench for sha256_core against a FIPS 180-4 reference model
// whose constants are derived from prime roots.
module tb_sha256_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_tvalid, s_tready, s_tlast;
  logic [3:0]  s_tkeep, m_tkeep;
  logic [31:0] s_tdata, m_tdata;
  logic        m_tvalid, m_tready, m_tlast;

  always #5 clk = ~clk;

  sha256_core dut (
    .m_axis_aclk    (clk),
    .m_axis_aresetn (rst),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tkeep   (s_tkeep),
    .s_axis_tready  (s_tready),
    .s_axis_tdata   (s_tdata),
    .s_axis_tlast   (s_tlast),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tkeep   (m_tkeep),
    .m_axis_tready  (m_tready),
    .m_axis_tdata   (m_tdata),
    .m_axis_tlast   (m_tlast)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] kt [64];
  logic [31:0] ht [8];
  logic [31:0] exp_dig [8];
  logic [31:0] exp_blk [16];
  logic [31:0] got_dig [8];
  logic [31:0] cap_w0, cap_w1, cap_w14, cap_w15;

  logic [31:0] ABC_D [8] = '{
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
  };
  logic [31:0] A_D [8] = '{
    32'hca978112, 32'hca1bbdca, 32'hfac231b3, 32'h9a23dc4d,
    32'ha786eff8, 32'h147c4e72, 32'hb9807785, 32'hafee48bb
  };

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic bit is_prime(input int n);
    for (int d = 2; d * d <= n; d++)
      if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  // K and H0 from fractional parts of cube and square roots of primes
  task automatic gen_consts;
    int  p;
    int  c;
    real f;
    p = 2;
    c = 0;
    while (c < 64) begin
      if (is_prime(p)) begin
        f = $pow(real'(p), 1.0 / 3.0);
        f = f - $floor(f);
        kt[c] = 32'(longint'($floor(f * 4294967296.0)));
        if (c < 8) begin
          f = $sqrt(real'(p));
          f = f - $floor(f);
          ht[c] = 32'(longint'($floor(f * 4294967296.0)));
        end
        c++;
      end
      p++;
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  task automatic ref_sha(input logic [7:0] msg[$]);
    logic [7:0]  b [64];
    logic [31:0] w [64];
    logic [31:0] r [8];
    logic [31:0] s0, s1, ch, mj, x1, x2;
    logic [63:0] bits;
    int n;
    n = (msg.size() > 55) ? 55 : msg.size();
    for (int i = 0; i < 64; i++) b[i] = 8'h00;
    for (int i = 0; i < n; i++) b[i] = msg[i];
    b[n] = 8'h80;
    bits = 64'(n) * 64'd8;
    for (int j = 0; j < 8; j++) b[56 + j] = bits[63 - 8 * j -: 8];
    for (int t = 0; t < 16; t++)
      w[t] = {b[4*t], b[4*t+1], b[4*t+2], b[4*t+3]};
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    for (int i = 0; i < 16; i++) exp_blk[i] = w[i];
    for (int i = 0; i < 8; i++) r[i] = ht[i];
    for (int t = 0; t < 64; t++) begin
      s1 = rotr(r[4], 6) ^ rotr(r[4], 11) ^ rotr(r[4], 25);
      ch = (r[4] & r[5]) ^ (~r[4] & r[6]);
      x1 = r[7] + s1 + ch + kt[t] + w[t];
      s0 = rotr(r[0], 2) ^ rotr(r[0], 13) ^ rotr(r[0], 22);
      mj = (r[0] & r[1]) ^ (r[0] & r[2]) ^ (r[1] & r[2]);
      x2 = s0 + mj;
      for (int i = 7; i > 0; i--) r[i] = r[i-1];
      r[4] = r[4] + x1;
      r[0] = x1 + x2;
    end
    for (int i = 0; i < 8; i++) exp_dig[i] = ht[i] + r[i];
  endtask

  // Returns right at the posedge that accepts the tlast beat
  task automatic send_bytes(input logic [7:0] msg[$], input bit keep0);
    logic [31:0] rnd;
    for (int i = 0; i < msg.size(); i++) begin
      @(negedge clk);
      if (i > 0 && $urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0;
        @(negedge clk);
      end
      rnd      = $urandom();
      s_tvalid = 1'b1;
      s_tdata  = {rnd[31:8], msg[i]};
      s_tkeep  = keep0 ? 4'h0 : rnd[3:0];
      s_tlast  = (i == msg.size() - 1);
      chk("s_tready_idle", 32'(s_tready), 32'd1);
      @(posedge clk);
    end
  endtask

  task automatic run_msg(input logic [7:0] msg[$], input bit bp,
                         input bit junk, input bit keep0,
                         input bit hold_rdy, input string nm);
    int          lat, ngot, guard;
    bit          stalled;
    logic [31:0] held_d, rnd;
    logic        held_l;
    ref_sha(msg);
    m_tready = hold_rdy ? 1'b0 : 1'b1;
    send_bytes(msg, keep0);
    #1;
    s_tvalid = junk;
    s_tlast  = junk;
    lat = 0;
    while (1) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        cap_w0  = dut.w_array[0];
        cap_w1  = dut.w_array[1];
        cap_w14 = dut.w_array[14];
        cap_w15 = dut.w_array[15];
        chk({nm, "_w0"}, cap_w0, exp_blk[0]);
        chk({nm, "_w1"}, cap_w1, exp_blk[1]);
        chk({nm, "_w14"}, cap_w14, exp_blk[14]);
        chk({nm, "_w15"}, cap_w15, exp_blk[15]);
        chk({nm, "_busy_tready"}, 32'(s_tready), 32'd0);
      end
      if (m_tvalid || lat >= 300) break;
      if (junk) begin
        rnd     = $urandom();
        s_tdata = rnd;
        s_tlast = rnd[8];
      end
    end
    chk({nm, "_latency"}, 32'(lat), 32'd114);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    ngot = 0;
    guard = 0;
    stalled = 1'b0;
    held_d = '0;
    held_l = 1'b0;
    while (ngot < 8 && guard < 400) begin
      if (stalled) begin
        chk({nm, "_hold_data"}, m_tdata, held_d);
        chk({nm, "_hold_last"}, 32'(m_tlast), 32'(held_l));
      end
      m_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!m_tvalid) begin
        chk({nm, "_tvalid_held"}, 32'(m_tvalid), 32'd1);
        guard = 400;
      end else if (m_tready) begin
        got_dig[ngot] = m_tdata;
        chk($sformatf("%s_word%0d", nm, ngot), m_tdata, exp_dig[ngot]);
        chk($sformatf("%s_tlast%0d", nm, ngot), 32'(m_tlast),
            32'(ngot == 7));
        chk($sformatf("%s_tkeep%0d", nm, ngot), 32'(m_tkeep), 32'hF);
        ngot++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held_d  = m_tdata;
        held_l  = m_tlast;
      end
      @(posedge clk);
      #1;
      guard++;
    end
    chk({nm, "_nwords"}, 32'(ngot), 32'd8);
    chk({nm, "_tvalid_after"}, 32'(m_tvalid), 32'd0);
    chk({nm, "_s_tready_after"}, 32'(s_tready), 32'd1);
    chk({nm, "_w_cleared"}, dut.w_array[0], 32'd0);
    m_tready = 1'b1;
  endtask

  initial begin
    logic [7:0] msg[$];
    int seen;
    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    gen_consts();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_tready", 32'(s_tready), 32'd0);
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_m_tlast", 32'(m_tlast), 32'd0);
    chk("rst_m_tdata", m_tdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("first_s_tready", 32'(s_tready), 32'd1);

    msg = {8'h61, 8'h62, 8'h63};
    run_msg(msg, 1'b0, 1'b0, 1'b0, 1'b0, "abc");
    chk("abc_w0_lit", cap_w0, 32'h61626380);
    chk("abc_w15_lit", cap_w15, 32'h18);
    for (int i = 0; i < 8; i++)
      chk($sformatf("abc_lit%0d", i), got_dig[i], ABC_D[i]);

    msg = {8'h61};
    run_msg(msg, 1'b0, 1'b0, 1'b0, 1'b0, "a");
    for (int i = 0; i < 8; i++)
      chk($sformatf("a_lit%0d", i), got_dig[i], A_D[i]);

    msg = {8'h61, 8'h64, 8'h69, 8'h6f, 8'h73};
    run_msg(msg, 1'b0, 1'b0, 1'b1, 1'b1, "adios");
    chk("adios_w0_lit", cap_w0, 32'h6164696f);
    chk("adios_w1_lit", cap_w1, 32'h73800000);
    chk("adios_w15_lit", cap_w15, 32'h28);

    msg.delete();
    for (int i = 0; i < 40; i++) msg.push_back(8'($urandom()));
    run_msg(msg, 1'b1, 1'b1, 1'b0, 1'b0, "bp");

    // Abort mid-ROUND, then the next message must be clean
    msg = {8'h61, 8'h62, 8'h63};
    send_bytes(msg, 1'b0);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    repeat (80) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_s_tready", 32'(s_tready), 32'd0);
    chk("abort_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("abort_m_tdata", m_tdata, 32'd0);
    chk("abort_w0", dut.w_array[0], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_first_tready", 32'(s_tready), 32'd1);
    seen = 0;
    repeat (130) begin
      @(posedge clk);
      #1;
      if (m_tvalid) seen++;
    end
    chk("abort_no_output", 32'(seen), 32'd0);
    run_msg(msg, 1'b0, 1'b0, 1'b0, 1'b0, "abc2");
    for (int i = 0; i < 8; i++)
      chk($sformatf("abc2_lit%0d", i), got_dig[i], ABC_D[i]);

    msg.delete();
    for (int i = 0; i < 60; i++) msg.push_back(8'($urandom()));
    run_msg(msg, 1'b1, 1'b0, 1'b0, 1'b0, "long60");

    for (int k = 0; k < 4; k++) begin
      msg.delete();
      for (int i = 0; i < int'($urandom_range(1, 55)); i++)
        msg.push_back(8'($urandom()));
      run_msg(msg, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'b0, 1'b0, $sformatf("rnd%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
